// File: rtl/instruction_encoder_if.sv
// Field-in / word-out streaming bus between the program source, the encoder and the imem write port.
interface instruction_encoder_if;
  // Symbolic instruction fields (source -> encoder)
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  kind;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  shamt;
  logic [4:0]  alu_op;
  logic [31:0] imm;
  logic [31:0] target;
  // Encoded words with imem addresses (encoder -> imem)
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_addr;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_last, kind, rd, rs, rt, shamt, alu_op, imm, target, out_ready,
    input  in_ready, out_valid, out_addr, out_data
  );

  modport slave (
    input  in_valid, in_last, kind, rd, rs, rt, shamt, alu_op, imm, target, out_ready,
    output in_ready, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs symbolic instruction fields into 32-bit ISA words and streams them to imem
// with sequential addresses through a 2-entry FIFO; an FSM frames each program load.
module instruction_encoder (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  instruction_encoder_if.slave    bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [12:0]             word_count
);

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 13;
  localparam int unsigned MAX_WORDS = 4096;

  localparam logic [3:0] K_ALU  = 4'd0;
  localparam logic [3:0] K_ADDI = 4'd1;
  localparam logic [3:0] K_SW   = 4'd2;
  localparam logic [3:0] K_LW   = 4'd3;
  localparam logic [3:0] K_J    = 4'd4;
  localparam logic [3:0] K_BNE  = 4'd5;
  localparam logic [3:0] K_JAL  = 4'd6;
  localparam logic [3:0] K_JR   = 4'd7;
  localparam logic [3:0] K_BLT  = 4'd8;
  localparam logic [3:0] K_BEX  = 4'd9;
  localparam logic [3:0] K_SETX = 4'd10;
  localparam logic [3:0] K_MUL  = 4'd11;
  localparam logic [3:0] K_DIV  = 4'd12;

  localparam logic [4:0] OP_R    = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21;
  localparam logic [4:0] OP_BEX  = 5'd22;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [1:0]          count_q, count_d;
  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   tail_q, tail_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [DATA_W-1:0]   enc_word;
  logic                enc_err;
  logic [4:0]          alu_sel;
  logic [26:0]         i_body;
  logic                imm_oor;
  logic                tgt_oor;
  logic                push;
  logic                pop;
  logic                last_slot;

  assign i_body    = {bus.rd, bus.rs, bus.imm[16:0]};
  assign imm_oor   = (bus.imm[31:16] != {16{bus.imm[16]}});
  assign tgt_oor   = |bus.target[31:27];
  assign push      = bus.in_valid && in_ready_q;
  assign pop       = out_valid_q && bus.out_ready;
  assign last_slot = (word_count_q == CNT_W'(MAX_WORDS - 1));

  // Combinational encode of the presented fields; faulty inputs become a nop
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    alu_sel  = bus.alu_op;
    case (bus.kind)
      K_ALU, K_MUL, K_DIV: begin
        if (bus.kind == K_MUL) alu_sel = 5'd6;
        else if (bus.kind == K_DIV) alu_sel = 5'd7;
        enc_word = {OP_R, bus.rd, bus.rs, bus.rt, bus.shamt, alu_sel, 2'b00};
      end
      K_ADDI: begin enc_word = {OP_ADDI, i_body}; enc_err = imm_oor; end
      K_SW:   begin enc_word = {OP_SW,   i_body}; enc_err = imm_oor; end
      K_LW:   begin enc_word = {OP_LW,   i_body}; enc_err = imm_oor; end
      K_BNE:  begin enc_word = {OP_BNE,  i_body}; enc_err = imm_oor; end
      K_BLT:  begin enc_word = {OP_BLT,  i_body}; enc_err = imm_oor; end
      K_J:    begin enc_word = {OP_J,    bus.target[26:0]}; enc_err = tgt_oor; end
      K_JAL:  begin enc_word = {OP_JAL,  bus.target[26:0]}; enc_err = tgt_oor; end
      K_SETX: begin enc_word = {OP_SETX, bus.target[26:0]}; enc_err = tgt_oor; end
      K_BEX:  begin enc_word = {OP_BEX,  bus.target[26:0]}; enc_err = tgt_oor; end
      K_JR:   enc_word = {OP_JR, bus.rd, 22'd0};
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_word = '0;
  end

  // Next-state, FIFO and counter logic; output flops are loaded from next-state values
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    err_d        = err_q;

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = enc_word;
        else                 tail_d = enc_word;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: head_d = enc_word;   // only reachable with one entry: head replaced, count held
      default: ;
    endcase

    if (push) begin
      word_count_d = word_count_q + CNT_W'(1);
      if (enc_err || (last_slot && !bus.in_last)) err_d = 1'b1;
    end
    if (pop) addr_d = addr_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LOAD;
          word_count_d = '0;
          err_d        = 1'b0;
          addr_d       = '0;
        end
      end
      LOAD:    if (push && (bus.in_last || last_slot)) state_d = DRAIN;
      DRAIN:   if (count_q == 2'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == LOAD) && (count_d < 2'd2);
    out_valid_d = (count_d != 2'd0);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DRAIN) && (count_d == 2'd0);
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FIFO, counters and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_data  = head_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: encodes, errors, backpressure, reset and word limit.
module tb_instruction_encoder;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [12:0] word_count;

  instruction_encoder_if bus_if();

  instruction_encoder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .bus        (bus_if),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int n_timeouts = 0;

  logic [11:0] mon_addr[$];
  logic [31:0] mon_data[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every word that will be popped at the coming rising edge
  always @(negedge clock) begin
    if (reset_n && bus_if.out_valid && bus_if.out_ready) begin
      mon_addr.push_back(bus_if.out_addr);
      mon_data.push_back(bus_if.out_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_fields(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] op,
                            input logic [31:0] imm, input logic [31:0] tgt, input logic last);
    bus_if.kind    = k;
    bus_if.rd      = rd;
    bus_if.rs      = rs;
    bus_if.rt      = rt;
    bus_if.shamt   = sh;
    bus_if.alu_op  = op;
    bus_if.imm     = imm;
    bus_if.target  = tgt;
    bus_if.in_last = last;
  endtask

  // Present one word and hold it until accepted (bounded)
  task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] op,
                      input logic [31:0] imm, input logic [31:0] tgt, input logic last);
    logic acc;
    set_fields(k, rd, rs, rt, sh, op, imm, tgt, last);
    bus_if.in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      acc = bus_if.in_ready;
      tick();
      if (acc) break;
    end
    bus_if.in_valid = 1'b0;
    if (!acc) n_timeouts++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) for the done pulse and confirm it lasts one cycle
  task automatic wait_done(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, 32'(found), 32'd1);
    if (found) begin
      tick();
      check_eq({tag, "_one_cycle"}, 32'(done), 32'd0);
      check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic seen_done;
    int   n_bad;

    reset_n          = 1'b0;
    start            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    set_fields(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);

    // Reset values
    tick(); tick();
    check_eq("rst_in_ready",  32'(bus_if.in_ready),  32'd0);
    check_eq("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("rst_out_addr",  32'(bus_if.out_addr),  32'd0);
    check_eq("rst_out_data",  bus_if.out_data,       32'd0);
    check_eq("rst_busy",      32'(busy),             32'd0);
    check_eq("rst_done",      32'(done),             32'd0);
    check_eq("rst_err",       32'(err),              32'd0);
    check_eq("rst_word_count",32'(word_count),       32'd0);
    reset_n = 1'b1;
    tick();

    // Single addi load with end-of-program marker
    do_start();
    check_eq("t1_busy",     32'(busy),            32'd1);
    check_eq("t1_in_ready", 32'(bus_if.in_ready), 32'd1);
    bus_if.out_ready = 1'b1;
    send(4'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 32'd5, 32'd0, 1'b1);
    check_eq("t1_out_valid", 32'(bus_if.out_valid), 32'd1);
    check_eq("t1_out_data",  bus_if.out_data,       32'h2840_0005);
    check_eq("t1_out_addr",  32'(bus_if.out_addr),  32'd0);
    check_eq("t1_word_count",32'(word_count),       32'd1);
    wait_done("t1_done");
    check_eq("t1_err",       32'(err),              32'd0);
    check_eq("t1_addr_after",32'(bus_if.out_addr),  32'd1);

    // R, JII, JI and lower-bound I encodes
    mon_addr.delete(); mon_data.delete();
    do_start();
    send(4'd11, 5'd3,  5'd1, 5'd2, 5'd0, 5'd9, 32'd0, 32'd0, 1'b0);
    send(4'd7,  5'd31, 5'd7, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    send(4'd9,  5'd0,  5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0100, 1'b0);
    send(4'd1,  5'd2,  5'd3, 5'd0, 5'd0, 5'd0, 32'hFFFF_0000, 32'd0, 1'b1);
    wait_done("t2_done");
    check_eq("t2_n_words", 32'(mon_data.size()), 32'd4);
    check_eq("t2_mul",     mon_data[0], 32'h00C2_2018);
    check_eq("t2_jr",      mon_data[1], 32'h27C0_0000);
    check_eq("t2_bex",     mon_data[2], 32'hB000_0100);
    check_eq("t2_addi_min",mon_data[3], 32'h2887_0000);
    check_eq("t2_addr3",   32'(mon_addr[3]), 32'd3);
    check_eq("t2_err",     32'(err), 32'd0);
    check_eq("t2_word_count", 32'(word_count), 32'd4);

    // Out-of-range and invalid inputs become nops and set err
    mon_addr.delete(); mon_data.delete();
    do_start();
    send(4'd1,  5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 32'd70000, 32'd0, 1'b0);
    check_eq("t3_err_imm", 32'(err), 32'd1);
    send(4'd4,  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0800_0000, 1'b0);
    send(4'd14, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
    wait_done("t3_done");
    check_eq("t3_n_words", 32'(mon_data.size()), 32'd3);
    check_eq("t3_nop_imm", mon_data[0], 32'd0);
    check_eq("t3_nop_tgt", mon_data[1], 32'd0);
    check_eq("t3_nop_kind",mon_data[2], 32'd0);
    check_eq("t3_addr2",   32'(mon_addr[2]), 32'd2);
    check_eq("t3_err_sticky", 32'(err), 32'd1);
    check_eq("t3_word_count", 32'(word_count), 32'd3);
    mon_addr.delete(); mon_data.delete();
    do_start();
    check_eq("t3_err_cleared", 32'(err), 32'd0);
    check_eq("t3_wc_cleared",  32'(word_count), 32'd0);
    send(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd5, 1'b1);
    wait_done("t3b_done");
    check_eq("t3_setx", mon_data[0], 32'hA800_0005);

    // Backpressure: FIFO fills after two words, head holds at address 0
    mon_addr.delete(); mon_data.delete();
    bus_if.out_ready = 1'b0;
    do_start();
    send(4'd3, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    send(4'd0, 5'd7, 5'd8, 5'd9, 5'd3, 5'd2, 32'd0, 32'd0, 1'b0);
    set_fields(4'd2, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 32'd8, 32'd0, 1'b1);
    bus_if.in_valid = 1'b1;
    tick(); tick(); tick();
    check_eq("t4_in_ready_full", 32'(bus_if.in_ready), 32'd0);
    check_eq("t4_head_addr",     32'(bus_if.out_addr), 32'd0);
    check_eq("t4_head_data",     bus_if.out_data,      32'h410B_FFFF);
    check_eq("t4_word_count",    32'(word_count),      32'd2);
    bus_if.out_ready = 1'b1;
    send(4'd2, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 32'd8, 32'd0, 1'b1);
    wait_done("t4_done");
    check_eq("t4_n_words", 32'(mon_data.size()), 32'd3);
    check_eq("t4_addr0", 32'(mon_addr[0]), 32'd0);
    check_eq("t4_addr1", 32'(mon_addr[1]), 32'd1);
    check_eq("t4_addr2", 32'(mon_addr[2]), 32'd2);
    check_eq("t4_data0", mon_data[0], 32'h410B_FFFF);
    check_eq("t4_data1", mon_data[1], 32'h01D0_9188);
    check_eq("t4_data2", mon_data[2], 32'h3844_0008);

    // Reset in the middle of a load with two words buffered
    bus_if.out_ready = 1'b0;
    do_start();
    send(4'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 32'd1, 32'd0, 1'b0);
    send(4'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 32'd2, 32'd0, 1'b0);
    check_eq("t5_pre_out_valid", 32'(bus_if.out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_out_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("t5_busy",      32'(busy),             32'd0);
    check_eq("t5_in_ready",  32'(bus_if.in_ready),  32'd0);
    check_eq("t5_word_count",32'(word_count),       32'd0);
    seen_done = 1'b0;
    tick();
    reset_n = 1'b1;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      seen_done = seen_done | done;
      tick();
    end
    check_eq("t5_no_done", 32'(seen_done), 32'd0);
    check_eq("t5_idle_busy", 32'(busy), 32'd0);

    // 4096 words without end marker: limit stops the load and flags err
    mon_addr.delete(); mon_data.delete();
    do_start();
    for (int i = 0; i < 4096; i++)
      send(4'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'(i), 32'd0, 1'b0);
    check_eq("t6_err",       32'(err),             32'd1);
    check_eq("t6_word_count",32'(word_count),      32'd4096);
    check_eq("t6_in_ready",  32'(bus_if.in_ready), 32'd0);
    check_eq("t6_busy",      32'(busy),            32'd1);
    wait_done("t6_done");
    check_eq("t6_n_words", 32'(mon_data.size()), 32'd4096);
    check_eq("t6_last_addr", 32'(mon_addr[mon_addr.size() - 1]), 32'd4095);
    check_eq("t6_last_data", mon_data[mon_data.size() - 1], 32'h2800_0FFF);
    n_bad = 0;
    for (int i = 0; i < mon_addr.size(); i++)
      if (mon_addr[i] != 12'(i)) n_bad++;
    check_eq("t6_addr_seq", 32'(n_bad), 32'd0);

    check_eq("send_timeouts", 32'(n_timeouts), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Streaming encoder and program loader that performs the inverse of instruction decode: it takes symbolic instruction fields over a valid/ready handshake, packs them into 32-bit ISA words, and emits them with sequential instruction-memory addresses. It sits between the test/boot program source and the imem write port. A 2-entry output FIFO decouples the two sides. A small FSM frames each program load between `start` and `done`.

## Interface
- No parameters. Fixed values: address width 12, FIFO depth 2, maximum 4096 words per load.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load; honoured in IDLE only.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: encoder accepts the input fields this cycle.
- `in_last` in 1: the current input word is the final word of the program.
- `kind` in 4: instruction kind. 0 alu, 1 addi, 2 sw, 3 lw, 4 j, 5 bne, 6 jal, 7 jr, 8 blt, 9 bex, 10 setx, 11 mul, 12 div. Values 13–15 are invalid.
- `rd`, `rs`, `rt` in 5 each: register fields.
- `shamt`, `alu_op` in 5 each: R-type fields.
- `imm` in 32: signed immediate.
- `target` in 32: unsigned jump target.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: imem side accepts the head.
- `out_addr` out 12: imem address of the head word.
- `out_data` out 32: encoded head word.
- `busy` out 1: high when the FSM is in LOAD or DRAIN.
- `done` out 1: one-cycle pulse at the end of a load.
- `err` out 1: sticky error flag; cleared when a load starts.
- `word_count` out 13: number of words accepted in the current load.

## Operation
- Opcodes: alu/mul/div 0, j 1, bne 2, jal 3, jr 4, addi 5, blt 6, sw 7, lw 8, setx 21, bex 22.
- R format (alu, mul, div):
  - [31:27] opcode, [26:22] rd, [21:17] rs, [16:12] rt, [11:7] shamt, [6:2] alu_op, [1:0] 0.
  - mul forces alu_op = 6; div forces alu_op = 7.
- I format (addi, sw, lw, bne, blt): opcode, rd, rs, [16:0] = imm[16:0].
  - Range error if imm is outside −65536..65535.
- JI format (j, jal, setx, bex): opcode, [26:0] = target[26:0].
  - Range error if target[31:27] ≠ 0.
- JII format (jr): opcode, [26:22] = rd, [21:0] = 0.
- Invalid kind or range error: push 0x00000000 (nop) in place of the word and set `err`. The word is still counted and addressed.
- FSM states: IDLE, LOAD, DRAIN.
  - IDLE → LOAD on `start`. Clears `word_count`, `err`, and the address counter.
  - LOAD → DRAIN when a word accepted with `in_last`=1, or when the accepted word is the 4096th. If that 4096th word had `in_last`=0, also set `err`.
  - DRAIN → IDLE when the FIFO is empty. `done` pulses on that transition cycle.
  - `start` in LOAD or DRAIN is ignored.
- `in_ready` = (state == LOAD) && (FIFO count < 2). There is no bypass: a full FIFO stalls input even if it pops in the same cycle.
- Push occurs on `in_valid && in_ready`. Pop occurs on `out_valid && out_ready`. Simultaneous push and pop leaves the count unchanged.
- Address counter: 12 bits. `out_addr` is the counter value. It increments on every pop and wraps from 4095 to 0 only between loads, because of the 4096-word limit.
- `word_count` increments on every push.

## Timing
- Reset values: state IDLE, FIFO empty, `in_ready` 0, `out_valid` 0, `out_addr` 0, `out_data` 0, `busy` 0, `done` 0, `err` 0, `word_count` 0.
- `start` sampled at edge N: state is LOAD and `in_ready` is 1 after edge N.
- Latency: word accepted at edge N into an empty FIFO appears with `out_valid` 1 after edge N. Combinational encode, registered FIFO.
- `out_data` and `out_addr` hold stable while `out_valid && !out_ready`.
- `done` is high for exactly one cycle. It asserts the cycle after the final pop empties the FIFO in DRAIN.
- `reset_n` low at any point: everything returns to reset values immediately. In-flight FIFO words are discarded and no `done` is produced.

## Test plan
- Reset, then `start`. Stream addi rd=1 rs=0 imm=5 with `in_last`, `out_ready`=1 → `out_data`=0x28400005, `out_addr`=0, then `done` pulse, `err`=0, `word_count`=1.
- R, JII and JI encodes:
  - mul rd=3 rs=1 rt=2 → 0x00C22018.
  - jr rd=31 → 0x27C00000.
  - bex target=0x100 → 0xB0000100.
- Invalid and out-of-range inputs:
  - addi imm=70000 → `out_data` 0, `err`=1.
  - kind=14 → `out_data` 0, `err`=1.
  - Next `start` clears `err`.
- Backpressure: `out_ready`=0, push 3 words → `in_ready` drops after 2 and the head holds at addr 0. Release → addrs 0,1,2 in order, no loss or duplication.
- Reset mid-load with 2 words buffered → `out_valid` 0, state IDLE, `done` never pulses.
- 4096 words without `in_last` → 4096th accepted, `err`=1, DRAIN, last `out_addr`=4095, `done` pulses.
